// File: rtl/axi4_lite_master_bridge.sv
// axi4_lite_master_bridge: single-outstanding AXI4-Lite master behind a simple core request port,
// reporting slave errors and aborting any transaction that outlives TIMEOUT_CYCLES.
module axi4_lite_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        m_axi_aclk_i,
    input  logic        m_axi_aresetn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] m_axi_awaddr_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,
    output logic [31:0] m_axi_araddr_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

    state_e      state_q, state_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, cnt_q, cnt_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic        expire;

    assign req_ready_o     = state_q == IDLE;
    assign m_axi_awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign m_axi_wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign m_axi_bready_o  = state_q == WR_RESP;
    assign m_axi_arvalid_o = state_q == RD_REQ;
    assign m_axi_rready_o  = state_q == RD_RESP;
    assign m_axi_awaddr_o  = addr_q;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_wdata_o   = wdata_q;
    assign m_axi_wstrb_o   = wstrb_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_err_o      = resp_err_q;
    assign resp_rdata_o    = rdata_q;

    // cnt_q counts busy cycles since acceptance, so expiry lands on the TIMEOUT_CYCLES-th busy cycle.
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = (state_q == IDLE) ? cnt_q : cnt_q + 32'd1;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = 32'd0;
        case (state_q)
            IDLE: if (req_valid_i) begin
                addr_d    = req_addr_i;
                wdata_d   = req_wdata_i;
                wstrb_d   = req_wstrb_i;
                cnt_d     = 32'd0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = req_write_i ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                aw_done_d = aw_done_q || (m_axi_awvalid_o && m_axi_awready_i);
                w_done_d  = w_done_q || (m_axi_wvalid_o && m_axi_wready_i);
                state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
            end
            WR_RESP: if (m_axi_bvalid_i) begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = m_axi_bresp_i[1];
            end
            RD_REQ: state_d = m_axi_arready_i ? RD_RESP : RD_REQ;
            RD_RESP: if (m_axi_rvalid_i) begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = m_axi_rresp_i[1];
                rdata_d      = m_axi_rresp_i[1] ? 32'd0 : m_axi_rdata_i;
            end
            default: state_d = IDLE;
        endcase
        // A handshake that completes on the expiry cycle has already advanced state_d and wins.
        if (state_q != IDLE && state_d == state_q && expire) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge m_axi_aclk_i or negedge m_axi_aresetn_i) begin
        if (!m_axi_aresetn_i) begin
            state_q      <= IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            cnt_q        <= 32'd0;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end
endmodule
